gate_sequencer: RTL and testbench
=================================

Name: gate_sequencer

Overview:
Multi-gate transfer sequencer that drives the sync, TX-start, RX-pull and transfer-clock strobes for GATE_NUMBER gates. It is the parametrised successor to the single-shot gate state machine. It adds a programmable burst length (finite or continuous), a per-gate enable mask, a ready-wait timeout with stall capture, abort, and done/error reporting. It sits between the control/CSR logic and the gate TX/RX engines.

Parameters:
GATE_NUMBER, 8, number of gates sequenced.
CYCLE_W, 16, width of the burst-length input and the cycle counter.
TIMEOUT, 1024, maximum WAIT cycles before error. Must be ≥1. The timeout counter width is $clog2(TIMEOUT+1).

Ports:
i_clk  in  1  clock; all logic on its rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_start  in  1  start request; sampled in IDLE only.
i_abort  in  1  abort; takes priority over every transition.
i_cycles  in  CYCLE_W  burst length N, latched at start; 0 = continuous.
i_gate_mask  in  GATE_NUMBER  1 = gate participates; latched at start.
i_tx_ready  in  GATE_NUMBER  per-gate TX ready.
i_rx_ready  in  GATE_NUMBER  per-gate RX ready.
o_gen_sync  out  1  high while in IDLE.
o_tx_start  out  1  TX start strobe.
o_rx_pull  out  1  RX pull strobe.
o_clock  out  1  transfer clock; high only in XFER.
o_busy  out  1  high in any state other than IDLE.
o_done  out  1  one-cycle pulse when a finite burst completes.
o_error  out  1  one-cycle pulse on timeout.
o_stall_mask  out  GATE_NUMBER  gates not ready at timeout; held until the next accepted start.
o_cycle_cnt  out  CYCLE_W  completed XFER count; cleared at start, wraps in continuous mode.

Behaviour:
- Reset (asynchronous, i_rst_n=0): state=IDLE, o_gen_sync=1, all other outputs 0, counters 0, latched mask 0.
- All strobes are Moore decodes of the state register plus latched registers. There is no combinational path from inputs to outputs.
- ready = &((i_tx_ready & i_rx_ready) | ~mask_q). An all-zero mask makes ready constantly 1.
- States: IDLE, PRIME, WAIT, XFER, DONE, ERR.
- IDLE: when i_start=1 and i_abort=0:
  - latch rem_q=i_cycles and mask_q=i_gate_mask;
  - clear o_cycle_cnt and o_stall_mask;
  - go to PRIME.
- PRIME: o_tx_start=1 for one cycle, then go to WAIT. The timeout counter is cleared on every entry to WAIT.
- WAIT:
  - ready=1 → XFER (ready wins over timeout if both occur in the same cycle).
  - Otherwise the counter increments. When it reaches TIMEOUT-1 while still not ready → ERR, and o_stall_mask <= mask_q & ~(i_tx_ready & i_rx_ready) is captured.
- XFER:
  - o_clock=1 and o_rx_pull=1.
  - o_tx_start=1 unless this is the last pull of a finite burst (rem_q==1).
  - o_cycle_cnt increments.
  - Finite burst: rem_q decrements; rem_q==1 → DONE, else → WAIT.
  - Continuous burst (latched 0): always → WAIT; rem_q is not decremented.
- Strobe totals: a finite burst of N gives exactly N rx pulls and N tx starts (PRIME plus N-1 XFER). It also gives N clock pulses.
- DONE: o_done=1 for one cycle, then go to IDLE.
- ERR: o_error=1 for one cycle, then go to IDLE.
- Abort: i_abort=1 in any non-IDLE state → IDLE on the next edge.
  - No o_done or o_error pulse.
  - o_cycle_cnt holds its value.
- i_start while busy is ignored. Input changes to i_cycles and i_gate_mask mid-burst have no effect.
- Minimum XFER spacing is 2 cycles (WAIT→XFER→WAIT) when ready is held high.

Test Plan:
- Reset, then i_cycles=3, mask=all ones, all ready high, pulse start → exactly:
  - cycle sequence PRIME, WAIT, XFER, WAIT, XFER, WAIT, XFER, DONE;
  - 3 tx_start, 3 rx_pull, 3 o_clock pulses;
  - one o_done pulse, o_cycle_cnt=3, then IDLE with o_gen_sync=1.
- mask=8'b0000_0001, gate 5 ready held low, gate 0 ready → burst completes normally (masked gate ignored).
- TIMEOUT=16, gate 2 rx_ready held low → ERR reached 16 cycles after WAIT entry, o_error pulse, o_stall_mask=8'b0000_0100; the mask clears on the next start.
- i_cycles=0, ready high, abort after 10 XFERs → continuous strobes, o_cycle_cnt=10 held, no o_done, IDLE next cycle.
- i_rst_n asserted mid-WAIT (asynchronously, between edges) → outputs reach reset values immediately. A subsequent start with i_cycles=1 gives PRIME, WAIT, XFER (rx_pull=1, tx_start=0), DONE.
- Ready and timeout reached in the same cycle → XFER taken, no error. Start asserted during busy → ignored, burst length unchanged.

Source files
------------

// File: rtl/gate_sequencer.sv
// gate_sequencer: multi-gate transfer sequencer driving sync / TX-start / RX-pull /
// transfer-clock strobes, with programmable burst length, gate mask, ready timeout and abort.
// Latency: start accepted in IDLE -> PRIME next cycle; min XFER spacing 2 cycles.
// Backpressure: waits in WAIT for all masked gates ready; after TIMEOUT cycles -> ERR.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_start, i_abort      start request (IDLE only), abort (any non-IDLE state)
//   i_cycles              burst length (0 = continuous), latched at start
//   i_gate_mask           participating gates, latched at start
//   i_tx_ready/i_rx_ready per-gate readiness
//   o_gen_sync, o_tx_start, o_rx_pull, o_clock, o_busy, o_done, o_error  state strobes
//   o_stall_mask          gates not ready at timeout, held until next start
//   o_cycle_cnt           completed XFER count
module gate_sequencer #(
    parameter int GATE_NUMBER = 8,
    parameter int CYCLE_W     = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [CYCLE_W-1:0]     i_cycles,
    input  logic [GATE_NUMBER-1:0] i_gate_mask,
    input  logic [GATE_NUMBER-1:0] i_tx_ready,
    input  logic [GATE_NUMBER-1:0] i_rx_ready,
    output logic                   o_gen_sync,
    output logic                   o_tx_start,
    output logic                   o_rx_pull,
    output logic                   o_clock,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [GATE_NUMBER-1:0] o_stall_mask,
    output logic [CYCLE_W-1:0]     o_cycle_cnt
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_WAIT  = 3'd2,
        S_XFER  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CYCLE_W-1:0]     r_rem;
    logic [GATE_NUMBER-1:0] r_mask;
    logic [TO_W-1:0]        r_to_cnt;
    logic [CYCLE_W-1:0]     r_cycle_cnt;
    logic [GATE_NUMBER-1:0] r_stall;

    logic w_ready;
    logic w_last;
    logic w_timeout;
    logic w_start_ok;

    // Unmasked gates always count as ready, so an empty mask never stalls.
    assign w_ready    = &((i_tx_ready & i_rx_ready) | ~r_mask);
    // Continuous bursts latch 0 and never decrement, so this only fires for finite bursts.
    assign w_last     = (r_rem == CYCLE_W'(1));
    assign w_timeout  = (r_to_cnt == TO_LAST);
    assign w_start_ok = (r_state == S_IDLE) && i_start && !i_abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_PRIME;
            S_PRIME: w_next = S_WAIT;
            S_WAIT: begin
                // Ready wins over timeout in the same cycle.
                if (w_ready)        w_next = S_XFER;
                else if (w_timeout) w_next = S_ERR;
            end
            S_XFER:  w_next = w_last ? S_DONE : S_WAIT;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_mask      <= '0;
            r_to_cnt    <= '0;
            r_cycle_cnt <= '0;
            r_stall     <= '0;
        end else begin
            r_state <= w_next;

            if (w_start_ok) begin
                r_rem       <= i_cycles;
                r_mask      <= i_gate_mask;
                r_cycle_cnt <= '0;
                r_stall     <= '0;
            end

            // Fresh timeout window on every WAIT entry.
            if ((w_next == S_WAIT) && (r_state != S_WAIT))
                r_to_cnt <= '0;
            else if ((r_state == S_WAIT) && !w_ready)
                r_to_cnt <= r_to_cnt + 1'b1;

            // The XFER cycle has already issued its pull and clock, so it is
            // counted even if an abort arrives in the same cycle.
            if (r_state == S_XFER) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
                if (r_rem != '0) r_rem <= r_rem - 1'b1;
            end

            if ((r_state == S_WAIT) && (w_next == S_ERR))
                r_stall <= r_mask & ~(i_tx_ready & i_rx_ready);
        end
    end

    // Moore decodes only: no input reaches an output combinationally.
    assign o_gen_sync   = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_tx_start   = (r_state == S_PRIME) || ((r_state == S_XFER) && !w_last);
    assign o_rx_pull    = (r_state == S_XFER);
    assign o_clock      = (r_state == S_XFER);
    assign o_done       = (r_state == S_DONE);
    assign o_error      = (r_state == S_ERR);
    assign o_stall_mask = r_stall;
    assign o_cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_gate_sequencer.sv
// tb_gate_sequencer: table-driven burst vectors, hand sequences for abort / async reset /
// ready-at-timeout, and randomized bursts checked per cycle against a trace generator.
// Clock period 10; inputs driven #1 after posedge, outputs sampled on negedge.
module tb_gate_sequencer;

    localparam int G  = 8;
    localparam int CW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [CW-1:0] cycles;
    logic [G-1:0]  gmask, tx_rdy, rx_rdy;
    logic          gen_sync, tx_start, rx_pull, clock, busy, done, error;
    logic [G-1:0]  stall;
    logic [CW-1:0] ccnt;

    always #5 clk = ~clk;

    gate_sequencer #(.GATE_NUMBER(G), .CYCLE_W(CW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_cycles(cycles), .i_gate_mask(gmask), .i_tx_ready(tx_rdy), .i_rx_ready(rx_rdy),
        .o_gen_sync(gen_sync), .o_tx_start(tx_start), .o_rx_pull(rx_pull), .o_clock(clock),
        .o_busy(busy), .o_done(done), .o_error(error), .o_stall_mask(stall), .o_cycle_cnt(ccnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe vector order: {gen_sync, tx_start, rx_pull, clock, busy, done, error}
    localparam logic [6:0] V_IDLE  = 7'b1000000;
    localparam logic [6:0] V_PRIME = 7'b0100100;
    localparam logic [6:0] V_WAIT  = 7'b0000100;
    localparam logic [6:0] V_DONE  = 7'b0000110;
    localparam logic [6:0] V_ERR   = 7'b0000101;

    typedef struct packed {
        logic [6:0]    s;
        logic [G-1:0]  st;
        logic [CW-1:0] cnt;
    } exp_t;

    logic [G-1:0] tx_a [256];
    logic [G-1:0] rx_a [256];
    exp_t         exp_q [$];

    function automatic exp_t mk(input logic [6:0] s, input logic [G-1:0] st, input int c);
        exp_t e;
        e.s   = s;
        e.st  = st;
        e.cnt = c[CW-1:0];
        return e;
    endfunction

    // Expected output trace for a finite burst of n, from the burst rules: a PRIME, then
    // per pull a wait that ends on the first ready cycle or after TO not-ready cycles,
    // then the pull itself; trace[0] is the cycle after start is sampled.
    task automatic build(input int n, input logic [G-1:0] m);
        int           t, cnt, w;
        bit           rdy, failed;
        logic [G-1:0] st;
        exp_q.delete();
        cnt = 0; st = '0; failed = 0;
        exp_q.push_back(mk(V_PRIME, st, cnt));
        t = 2;
        for (int k = 0; k < n && !failed; k++) begin
            w = 0;
            while (1) begin
                rdy = &((tx_a[t] & rx_a[t]) | ~m);
                exp_q.push_back(mk(V_WAIT, st, cnt));
                t++;
                if (rdy) break;
                w++;
                if (w == TO) begin
                    st = m & ~(tx_a[t-1] & rx_a[t-1]);
                    exp_q.push_back(mk(V_ERR, st, cnt));
                    failed = 1;
                    break;
                end
            end
            if (!failed) begin
                exp_q.push_back(mk({2'b00, 5'b11100} | ((k != n-1) ? 7'b0100000 : 7'b0), st, cnt));
                cnt++;
                t++;
                if (k == n-1) exp_q.push_back(mk(V_DONE, st, cnt));
            end
        end
        exp_q.push_back(mk(V_IDLE, st, cnt));
    endtask

    // Call in an IDLE cycle away from the edge; returns in the final IDLE cycle.
    task automatic run_trace(input int n, input logic [G-1:0] m, input bit noise);
        int   L;
        exp_t a;
        build(n, m);
        L = exp_q.size();
        start = 1'b1; cycles = CW'(n); gmask = m; tx_rdy = tx_a[0]; rx_rdy = rx_a[0];
        for (int t = 1; t <= L; t++) begin
            @(posedge clk); #1;
            start  = (noise && t < L) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                cycles = CW'($urandom_range(0, 9));
                gmask  = G'($urandom);
            end
            tx_rdy = tx_a[t]; rx_rdy = rx_a[t];
            @(negedge clk);
            a = {gen_sync, tx_start, rx_pull, clock, busy, done, error, stall, ccnt};
            chk($sformatf("trace n=%0d t=%0d", n, t), a, exp_q[t-1]);
        end
    endtask

    task automatic fill_ready(input logic [G-1:0] tv, input logic [G-1:0] rv);
        for (int i = 0; i < 256; i++) begin
            tx_a[i] = tv; rx_a[i] = rv;
        end
    endtask

    typedef struct {
        int           n;
        logic [G-1:0] m, tx, rx;
        int           e_tx, e_rx, e_clk, e_done, e_err, e_end, e_cnt;
        logic [G-1:0] e_stall;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int ntx, nrx, nclk, ndone, nerr, tend, tt;
        bit fin, seen_st;

        tbl[0] = '{3, 8'hFF, 8'hFF, 8'hFF, 3, 3, 3, 1, 0,  8, 3, 8'h00};
        tbl[1] = '{2, 8'h01, 8'hDF, 8'hFF, 2, 2, 2, 1, 0,  6, 2, 8'h00};
        tbl[2] = '{4, 8'h00, 8'h00, 8'h00, 4, 4, 4, 1, 0, 10, 4, 8'h00};
        tbl[3] = '{3, 8'hFF, 8'hFF, 8'hFB, 1, 0, 0, 0, 1, 18, 0, 8'h04};
        tbl[4] = '{1, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 1, 0,  4, 1, 8'h00};
        tbl[5] = '{2, 8'h30, 8'hEF, 8'hFF, 1, 0, 0, 0, 1, 18, 0, 8'h10};

        rst_n = 1'b0; start = 0; abort = 0; cycles = '0; gmask = '0; tx_rdy = '0; rx_rdy = '0;
        #1;
        chk("reset strobes", {gen_sync, tx_start, rx_pull, clock, busy, done, error}, V_IDLE);
        chk("reset stall", stall, 0);
        chk("reset cnt", ccnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven bursts with constant readiness.
        foreach (tbl[i]) begin
            ntx = 0; nrx = 0; nclk = 0; ndone = 0; nerr = 0; tend = -1; fin = 0; seen_st = 0;
            start = 1; cycles = CW'(tbl[i].n); gmask = tbl[i].m;
            tx_rdy = tbl[i].tx; rx_rdy = tbl[i].rx;
            for (tt = 1; tt <= 100 && !fin; tt++) begin
                @(posedge clk); #1;
                start = 0;
                @(negedge clk);
                if (tt == 1) chk($sformatf("tbl%0d stall cleared", i), stall, 0);
                ntx += int'(tx_start); nrx += int'(rx_pull); nclk += int'(clock);
                ndone += int'(done); nerr += int'(error);
                if ((done || error) && tend < 0) tend = tt;
                if (gen_sync) fin = 1;
            end
            chk($sformatf("tbl%0d returned idle", i), fin, 1);
            chk($sformatf("tbl%0d tx_start count", i), ntx, tbl[i].e_tx);
            chk($sformatf("tbl%0d rx_pull count", i), nrx, tbl[i].e_rx);
            chk($sformatf("tbl%0d clock count", i), nclk, tbl[i].e_clk);
            chk($sformatf("tbl%0d done count", i), ndone, tbl[i].e_done);
            chk($sformatf("tbl%0d error count", i), nerr, tbl[i].e_err);
            chk($sformatf("tbl%0d end cycle", i), tend, tbl[i].e_end);
            chk($sformatf("tbl%0d cycle_cnt", i), ccnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d stall_mask", i), stall, tbl[i].e_stall);
        end

        // Exact per-cycle sequence for a 3-pull burst.
        fill_ready('1, '1);
        run_trace(3, 8'hFF, 0);

        // Ready arrives in the very cycle the timeout would fire: transfer, no error.
        fill_ready('1, '1);
        for (int t = 2; t <= 16; t++) rx_a[t] = 8'h00;
        run_trace(1, 8'hFF, 0);

        // Continuous burst, abort in WAIT after 10 transfers.
        ntx = 0; nclk = 0; ndone = 0; fin = 0;
        start = 1; cycles = '0; gmask = 8'hFF; tx_rdy = '1; rx_rdy = '1;
        for (tt = 1; tt <= 100 && !fin; tt++) begin
            @(posedge clk); #1;
            start = 0;
            @(negedge clk);
            ntx += int'(tx_start); nclk += int'(clock); ndone += int'(done);
            if (nclk == 10) fin = 1;
        end
        chk("cont reached 10 xfers", fin, 1);
        @(posedge clk); #1;
        abort = 1;
        @(negedge clk);
        chk("cont wait before abort", {gen_sync, tx_start, rx_pull, clock, busy, done, error}, V_WAIT);
        chk("cont cnt before abort", ccnt, 10);
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("abort to idle", {gen_sync, tx_start, rx_pull, clock, busy, done, error}, V_IDLE);
        chk("abort cnt held", ccnt, 10);
        chk("cont tx_start count", ntx, 11);
        chk("cont no done", ndone, 0);
        repeat (2) @(negedge clk);
        chk("abort cnt still held", ccnt, 10);

        // Asynchronous reset in the middle of WAIT.
        start = 1; cycles = 16'd5; gmask = 8'hFF; tx_rdy = '1; rx_rdy = '1;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre-reset wait", {busy, clock, ccnt}, {1'b1, 1'b0, 16'd2});
        #1 rst_n = 0;
        #1;
        chk("async reset strobes", {gen_sync, tx_start, rx_pull, clock, busy, done, error}, V_IDLE);
        chk("async reset cnt", ccnt, 0);
        @(negedge clk);
        rst_n = 1;
        fill_ready('1, '1);
        run_trace(1, 8'hFF, 0);

        // Randomized bursts with mid-burst noise on start / cycles / mask.
        for (int r = 0; r < 40; r++) begin
            int mode, g;
            mode = $urandom_range(0, 2);
            g    = $urandom_range(0, G-1);
            for (int i = 0; i < 256; i++) begin
                case (mode)
                    0:       begin tx_a[i] = '1; rx_a[i] = '1; end
                    1:       begin tx_a[i] = G'($urandom | $urandom); rx_a[i] = G'($urandom | $urandom); end
                    default: begin tx_a[i] = '1; rx_a[i] = '1; rx_a[i][g] = 1'b0; end
                endcase
            end
            run_trace($urandom_range(1, 4), G'($urandom), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
